// File: rtl/quantum_scheduler_if.sv
// Control-unit / PC-register side of the quantum scheduler.
// The control unit drives the master side and the scheduler implements the slave side.
interface quantum_scheduler_if #(
    parameter int NPROC = 4,
    parameter int QW    = 16
);
    localparam int IDW = $clog2(NPROC);

    logic             enable;
    logic             step;
    logic             halt;
    logic [31:0]      pc_cur;
    logic             quantum_load;
    logic [QW-1:0]    quantum_val;
    logic             proc_start;
    logic [IDW-1:0]   start_id;
    logic [31:0]      start_pc;
    logic             proc_exit;

    logic             pc_load;
    logic [31:0]      pc_next;
    logic [IDW-1:0]   proc_id;
    logic [NPROC-1:0] active_mask;
    logic             busy;
    logic             idle;
    logic [QW-1:0]    q_count;

    modport master (
        output enable, step, halt, pc_cur, quantum_load, quantum_val,
               proc_start, start_id, start_pc, proc_exit,
        input  pc_load, pc_next, proc_id, active_mask, busy, idle, q_count
    );

    modport slave (
        input  enable, step, halt, pc_cur, quantum_load, quantum_val,
               proc_start, start_id, start_pc, proc_exit,
        output pc_load, pc_next, proc_id, active_mask, busy, idle, q_count
    );
endinterface

// File: rtl/quantum_scheduler.sv
// Round-robin preemptive scheduler: counts retired instructions, saves the PC of the
// expiring process, picks the next active slot and strobes a one-cycle PC load.
module quantum_scheduler #(
    parameter int NPROC = 4,
    parameter int QW    = 16,
    parameter int QDEF  = 100
) (
    input logic                 clk,
    input logic                 reset_n,
    quantum_scheduler_if.slave  bus
);
    localparam int IDW = $clog2(NPROC);

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        SAVE,
        PICK,
        LOAD
    } state_t;

    state_t           state;
    state_t           state_nx;

    logic [IDW-1:0]   proc_id_q;
    logic [NPROC-1:0] active_q;
    logic [31:0]      pc_table [NPROC];
    logic [31:0]      pc_saved;
    logic [31:0]      pc_next_q;
    logic [QW-1:0]    quantum_q;
    logic [QW-1:0]    q_count_q;

    logic             count_en;
    logic             expire;
    logic             pick_hit;
    logic [IDW-1:0]   pick_id;
    logic [IDW-1:0]   cand;
    logic             start_fwd;

    // A quantum of zero never expires; ">=" lets a freshly shrunk quantum expire on the next step.
    always_comb begin
        count_en = bus.step && bus.enable && !bus.halt;
        expire   = count_en && (quantum_q != '0) && (q_count_q >= quantum_q - QW'(1));
    end

    // Search starts one past the running slot and wraps around to the running slot last.
    always_comb begin
        pick_hit = 1'b0;
        pick_id  = proc_id_q;
        cand     = proc_id_q;
        for (int i = 1; i <= NPROC; i++) begin
            cand = proc_id_q + IDW'(i);
            if (!pick_hit && active_q[cand]) begin
                pick_hit = 1'b1;
                pick_id  = cand;
            end
        end
    end

    assign start_fwd = bus.proc_start && (bus.start_id == pick_id);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= RUN;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (bus.proc_start || (active_q != '0)) begin
                    state_nx = PICK;
                end
            end
            RUN: begin
                if (bus.proc_exit) begin
                    state_nx = PICK;
                end else if (expire) begin
                    state_nx = SAVE;
                end
            end
            SAVE: state_nx = PICK;
            PICK: state_nx = pick_hit ? LOAD : IDLE;
            LOAD: state_nx = RUN;
            default: state_nx = RUN;
        endcase
    end

    // The proc_start write is placed last so it overrides a same-edge save or exit clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            proc_id_q <= '0;
            active_q  <= NPROC'(1);
            for (int i = 0; i < NPROC; i++) begin
                pc_table[i] <= '0;
            end
            pc_saved  <= '0;
            pc_next_q <= '0;
            quantum_q <= QW'(QDEF);
            q_count_q <= '0;
        end else begin
            if (bus.quantum_load) begin
                quantum_q <= bus.quantum_val;
            end

            unique case (state)
                RUN: begin
                    if (bus.proc_exit) begin
                        active_q[proc_id_q] <= 1'b0;
                        q_count_q           <= '0;
                    end else if (expire) begin
                        q_count_q <= '0;
                        pc_saved  <= bus.pc_cur;
                    end else if (count_en) begin
                        q_count_q <= q_count_q + QW'(1);
                    end
                end
                SAVE: begin
                    pc_table[proc_id_q] <= pc_saved;
                end
                PICK: begin
                    if (pick_hit) begin
                        proc_id_q <= pick_id;
                        pc_next_q <= start_fwd ? bus.start_pc : pc_table[pick_id];
                    end
                end
                LOAD: begin
                    q_count_q <= '0;
                end
                default: ;
            endcase

            if (bus.proc_start) begin
                pc_table[bus.start_id] <= bus.start_pc;
                active_q[bus.start_id] <= 1'b1;
            end
        end
    end

    assign bus.pc_load     = (state == LOAD);
    assign bus.busy        = (state == SAVE) || (state == PICK) || (state == LOAD);
    assign bus.idle        = (state == IDLE);
    assign bus.pc_next     = pc_next_q;
    assign bus.proc_id     = proc_id_q;
    assign bus.active_mask = active_q;
    assign bus.q_count     = q_count_q;

endmodule

// File: doc/quantum_scheduler.md
# quantum_scheduler

Round-robin preemptive scheduler for the processor's program counter. It counts instructions retired by the running process and, when its quantum expires, forces a context switch. On a switch it saves the current PC into a per-process table, picks the next active process, and issues a one-cycle PC load. It sits between the control unit (enable, process start/exit) and the PC register, and stalls the core through `busy` while a switch is in flight.

## Interface

Parameters:
- `NPROC`, 4: number of process slots; power of two, ≥2.
- `QW`, 16: quantum counter width.
- `QDEF`, 100: quantum value loaded at reset.

Ports:
- `clk`  in  1  single system clock (the divided CPU clock). All state changes on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  preemption enable (driven by `usaQuantum`).
- `step`  in  1  one-cycle pulse: one instruction retired by the running process.
- `halt`  in  1  core halted waiting for input; the quantum counter freezes.
- `pc_cur`  in  32  address of the next instruction of the running process.
- `quantum_load`  in  1  load `quantum_val` into the quantum register.
- `quantum_val`  in  QW  new quantum; 0 disables expiry.
- `proc_start`  in  1  register process `start_id` at `start_pc` and mark it active.
- `start_id`  in  log2(NPROC)  slot being started.
- `start_pc`  in  32  entry PC for `start_id`.
- `proc_exit`  in  1  running process terminated; clear its active bit.
- `pc_load`  out  1  one-cycle strobe: the PC must take `pc_next`.
- `pc_next`  out  32  PC of the process being dispatched.
- `proc_id`  out  log2(NPROC)  running process slot.
- `active_mask`  out  NPROC  one bit per active slot.
- `busy`  out  1  switch in progress; the core must not retire instructions.
- `idle`  out  1  no active process.
- `q_count`  out  QW  instructions retired in the current quantum.

## Operation

- States: IDLE, RUN, SAVE, PICK, LOAD.
- **Reset:**
  - state=RUN, proc_id=0, active_mask=1 (slot 0 active at PC 0).
  - PC table all 0, quantum=QDEF, q_count=0.
  - pc_load=0, pc_next=0, busy=0, idle=0.
- **RUN, counting:** q_count increments on a `step` pulse when `enable`=1 and `halt`=0.
  - With `enable`=0 or `halt`=1, q_count holds.
- **RUN, expiry:** a `step` pulse arriving with q_count==quantum-1 (quantum≠0 and `enable`=1) expires the quantum.
  - The same edge clears q_count, latches `pc_cur`, and moves to SAVE.
  - Quantum 0 never expires.
- **SAVE:** writes the latched PC to table[proc_id], then goes to PICK.
- **PICK:** round-robin search of active_mask starting at proc_id+1 mod NPROC, wrapping to proc_id itself.
  - A hit registers the next id and goes to LOAD.
  - No active slot: go to IDLE.
- **LOAD:**
  - Outputs: pc_load=1, pc_next=table[next], proc_id=next.
  - q_count is cleared; the next state is RUN.
- **`proc_exit` in RUN:** clears active_mask[proc_id], skips SAVE, and goes to PICK. `proc_exit` outside RUN is ignored.
- **IDLE:**
  - idle=1.
  - A `proc_start` moves to PICK on the next edge, then LOAD dispatches the started slot.
- **`proc_start`** is accepted in every state. It writes table[start_id]=start_pc and sets active_mask[start_id].
  - If SAVE writes the same slot on the same edge, the start wins.
  - Starting an already-active slot overwrites its PC.
- **`quantum_load`** takes effect on the next edge in any state and does not clear q_count.
  - If the new quantum ≤ q_count, expiry occurs on the next qualifying `step`. The comparison is q_count ≥ quantum-1.
- **Simultaneous events in RUN:** `proc_exit` has priority over expiry on the same edge. The `step` is still consumed and no save occurs.
- `busy`=1 in SAVE, PICK and LOAD. `step` pulses during busy are ignored; the core is required not to produce them.

## Timing

- Expiry to `pc_load` strobe: 3 cycles. The strobe is in the 3rd cycle after the expiring `step` edge: SAVE, PICK, LOAD.
- Exit to `pc_load`: 2 cycles (PICK, LOAD).
- `pc_next` is valid only while `pc_load`=1; it holds its last value otherwise.
- `busy` rises on the edge that leaves RUN and falls on the edge that leaves LOAD.
- Reset is asynchronous: assertion mid-switch immediately forces the reset values above. Release is synchronous to `clk`.

## Test plan

- **Expiry and round-robin:** NPROC=4, quantum=3. Start slot 1 at 0x40 and slot 2 at 0x80, then issue 3 steps from slot 0 with pc_cur=0x10.
  - Required: busy for 3 cycles, pc_load with pc_next=0x40, proc_id=1, table[0]=0x10.
  - After 3 more steps: dispatch of 0x80.
  - After 3 more: 0x10 for slot 0.
- **Single active process:** 2 steps with quantum=2 and pc_cur=0x5.
  - Required: pc_load with pc_next=0x5, proc_id=0.
- **Exit to idle:** `proc_exit` with only slot 0 active.
  - Required: idle=1 two cycles later, active_mask=0, no pc_load.
  - Then start slot 3 at 0x200: pc_load with 0x200 and proc_id=3 two cycles after the start.
- **Freeze and disable:** hold `halt`=1 or `enable`=0 while pulsing `step` 10 times with quantum=3.
  - Required: q_count unchanged, no switch.
  - Setting quantum=0 also prevents any switch.
- **Collisions:**
  - `proc_exit` and an expiring `step` on the same edge: no save, slot cleared.
  - `proc_start` to the running slot with start_pc=0x300 during SAVE: table holds 0x300.
- **Reset mid-switch:** assert reset_n=0 while in PICK.
  - Required: busy=0, pc_load=0, proc_id=0, active_mask=0001, q_count=0 immediately (without a clock edge).
